// File: rtl/graphics_pkg.sv
// graphics_pkg: frame buffer geometry, pixel field widths and flush FSM states
package graphics_pkg;
    localparam int PIXEL_COUNT = 256000;
    localparam int ADDR_W = 18;
    localparam int COLOR_W = 4;
    typedef enum logic [1:0] {FLUSH_IDLE, FLUSH_DRAINING, FLUSH_DONE} flush_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: single-clock, count-based FIFO whose head entry is always visible
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 22
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         head_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    always_ff @(posedge clock_in) begin
        if (push_in) r_mem[r_wr_ptr] <= data_in;
    end
    // Pointers wrap naturally at DEPTH; the count alone tells full from empty
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_in) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop_in) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, push_in} - {{AW{1'b0}}, pop_in};
        end
    end
    assign head_out  = r_mem[r_rd_ptr];
    assign count_out = r_count;
endmodule

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: decouples polygon-engine pixel writes from a stalling frame buffer,
// tracking dropped pixels and signalling flush completion.
module pixel_write_buffer import graphics_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int PIXEL_COUNT = graphics_pkg::PIXEL_COUNT
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     pixel_write_enable_in,
    input  logic [ADDR_W-1:0]        pixel_write_address_in,
    input  logic [COLOR_W-1:0]       pixel_write_data_in,
    input  logic                     flush_in,
    input  logic                     clear_status_in,
    output logic                     fb_write_enable_out,
    output logic [ADDR_W-1:0]        fb_write_address_out,
    output logic [COLOR_W-1:0]       fb_write_data_out,
    input  logic                     fb_ready_in,
    output logic [$clog2(DEPTH):0]   fill_level_out,
    output logic                     overflow_out,
    output logic                     range_error_out,
    output logic [15:0]              dropped_count_out,
    output logic                     flush_done_out
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W+COLOR_W-1:0] w_head;
    logic [CW-1:0]             w_fill;
    logic [CW-1:0]             w_next_fill;
    logic                      w_full, w_pop, w_push, w_in_range, w_ovf_drop, w_rng_drop;
    logic [15:0]               w_cnt_base;
    logic                      r_overflow, r_range_error, r_flush_done;
    logic [15:0]               r_dropped;
    flush_state_t              r_state;

    assign w_full      = w_fill == CW'(DEPTH);
    assign w_pop       = fb_write_enable_out && fb_ready_in;
    assign w_in_range  = 32'(pixel_write_address_in) < PIXEL_COUNT;
    assign w_push      = pixel_write_enable_in && w_in_range && (!w_full || w_pop);
    assign w_ovf_drop  = pixel_write_enable_in && w_in_range && w_full && !w_pop;
    assign w_rng_drop  = pixel_write_enable_in && !w_in_range;
    assign w_next_fill = w_fill + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    assign w_cnt_base  = clear_status_in ? 16'd0 : r_dropped;

    pixel_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W + COLOR_W)) u_fifo (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .push_in    (w_push),
        .data_in    ({pixel_write_address_in, pixel_write_data_in}),
        .pop_in     (w_pop),
        .head_out   (w_head),
        .count_out  (w_fill)
    );

    // A drop in the same cycle as a clear lands on top of the cleared value
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_overflow    <= 1'b0;
            r_range_error <= 1'b0;
            r_dropped     <= '0;
        end else begin
            r_overflow    <= (r_overflow && !clear_status_in) || w_ovf_drop;
            r_range_error <= (r_range_error && !clear_status_in) || w_rng_drop;
            r_dropped     <= ((w_ovf_drop || w_rng_drop) && w_cnt_base != 16'hFFFF) ? w_cnt_base + 16'd1 : w_cnt_base;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_state      <= FLUSH_IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                FLUSH_IDLE: if (flush_in) r_state <= FLUSH_DRAINING;
                FLUSH_DRAINING: if (w_next_fill == '0 && !w_push) begin
                    r_state      <= FLUSH_DONE;
                    r_flush_done <= 1'b1;
                end
                default: r_state <= FLUSH_IDLE;
            endcase
        end
    end

    assign fb_write_enable_out  = w_fill != '0;
    assign fb_write_address_out = fb_write_enable_out ? w_head[ADDR_W+COLOR_W-1:COLOR_W] : '0;
    assign fb_write_data_out    = fb_write_enable_out ? w_head[COLOR_W-1:0] : '0;
    assign fill_level_out       = w_fill;
    assign overflow_out         = r_overflow;
    assign range_error_out      = r_range_error;
    assign dropped_count_out    = r_dropped;
    assign flush_done_out       = r_flush_done;
endmodule
